// File: rtl/psum_accum_wb.sv
// Partial-sum accumulator with write-back: sums n_kij passes of n_out psum vectors,
// then drains the results (optionally ReLU-clamped) into the output SRAM.
//
// state | meaning
// IDLE  | waiting for start; no handshake, SRAM idle
// ACCUM | accepting vectors; kij==0 overwrites, later passes saturating-add
// DRAIN | one SRAM write per cycle for idx = 0..n_out-1
// DONE  | single-cycle seq_done pulse, then back to IDLE
module psum_accum_wb #(
    parameter int         col      = 8,
    parameter int         psum_bw  = 16,
    parameter int         n_out    = 16,
    parameter int         n_kij    = 9,
    parameter logic [8:0] out_base = 9'd0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   relu_en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [col*psum_bw-1:0] in_data,
    output logic [col*psum_bw-1:0] OP_d,
    output logic [8:0]             OP_addr,
    output logic                   OP_cen,
    output logic                   OP_wen,
    output logic                   seq_done,
    output logic                   busy,
    output logic                   sat_flag
);

    localparam int idx_w = (n_out > 1) ? $clog2(n_out) : 1;
    localparam int kij_w = (n_kij > 1) ? $clog2(n_kij) : 1;
    localparam logic [idx_w-1:0] idx_last = idx_w'(n_out - 1);
    localparam logic [kij_w-1:0] kij_last = kij_w'(n_kij - 1);
    localparam logic [psum_bw-1:0] sat_max = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] sat_min = {1'b1, {(psum_bw-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t             state, state_nxt;
    logic [idx_w-1:0]   idx;
    logic [kij_w-1:0]   kij;
    logic               relu_q;
    logic               xfer;
    logic               last_idx, last_kij;

    logic [psum_bw-1:0] acc [n_out][col];
    logic [psum_bw-1:0] lane [col];
    logic [psum_bw-1:0] acc_nxt [col];
    logic [col-1:0]     lane_sat;
    logic [psum_bw:0]   sum;

    assign xfer     = in_valid && (state == ACCUM);
    assign last_idx = (idx == idx_last);
    assign last_kij = (kij == kij_last);
    assign in_ready = (state == ACCUM);
    assign busy     = (state != IDLE);
    assign seq_done = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (xfer && last_idx && last_kij) state_nxt = DRAIN;
            DRAIN:   if (last_idx) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            kij      <= '0;
            relu_q   <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    idx      <= '0;
                    kij      <= '0;
                    relu_q   <= relu_en;
                    sat_flag <= 1'b0;
                end
                ACCUM: if (xfer) begin
                    if (|lane_sat) sat_flag <= 1'b1;
                    if (last_idx) begin
                        idx <= '0;
                        kij <= last_kij ? '0 : kij + 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DRAIN: idx <= last_idx ? '0 : idx + 1'b1;
                default: ;
            endcase
        end
    end

    // Sign-extend both operands one bit so overflow shows up as a top-two-bit mismatch.
    always_comb begin
        lane_sat = '0;
        sum      = '0;
        for (int i = 0; i < col; i++) begin
            lane[i]    = in_data[psum_bw*i +: psum_bw];
            sum        = {acc[idx][i][psum_bw-1], acc[idx][i]} + {lane[i][psum_bw-1], lane[i]};
            acc_nxt[i] = sum[psum_bw-1:0];
            if (kij == '0) begin
                acc_nxt[i] = lane[i];
            end else if (sum[psum_bw] != sum[psum_bw-1]) begin
                lane_sat[i] = 1'b1;
                acc_nxt[i]  = sum[psum_bw] ? sat_min : sat_max;
            end
        end
    end

    // Bank is deliberately not reset: pass 0 overwrites every entry.
    always_ff @(posedge clk) begin
        if (reset && xfer) begin
            for (int i = 0; i < col; i++) acc[idx][i] <= acc_nxt[i];
        end
    end

    always_comb begin
        OP_cen  = 1'b1;
        OP_wen  = 1'b1;
        OP_addr = '0;
        OP_d    = '0;
        if (state == DRAIN) begin
            OP_cen  = 1'b0;
            OP_wen  = 1'b0;
            OP_addr = out_base + 9'(idx);
            for (int i = 0; i < col; i++) begin
                if (relu_q && acc[idx][i][psum_bw-1]) OP_d[psum_bw*i +: psum_bw] = '0;
                else                                   OP_d[psum_bw*i +: psum_bw] = acc[idx][i];
            end
        end
    end

endmodule

// File: tb/tb_psum_accum_wb.sv
// Directed bench for psum_accum_wb: two instances (base 0 and base 500) share all inputs,
// writes are captured into a shadow memory and compared against hand-computed sums.
module tb_psum_accum_wb;
    localparam int W = 128;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, relu_en = 1'b0, in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic in_ready0, in_ready1, op_cen0, op_cen1, op_wen0, op_wen1;
    logic seq_done0, seq_done1, busy0, busy1, sat_flag0, sat_flag1;
    logic [W-1:0] op_d0, op_d1;
    logic [8:0] op_addr0, op_addr1;

    always #5 clk = ~clk;

    psum_accum_wb #(.out_base(9'd0)) u0 (
        .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .OP_d(op_d0), .OP_addr(op_addr0), .OP_cen(op_cen0), .OP_wen(op_wen0),
        .seq_done(seq_done0), .busy(busy0), .sat_flag(sat_flag0));

    psum_accum_wb #(.out_base(9'd500)) u1 (
        .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .OP_d(op_d1), .OP_addr(op_addr1), .OP_cen(op_cen1), .OP_wen(op_wen1),
        .seq_done(seq_done1), .busy(busy1), .sat_flag(sat_flag1));

    int checks = 0, errors = 0, cyc = 0;
    int wr_cnt, done_cnt, first_wr_cyc, last_wr_cyc, done_cyc, last_xfer_cyc;
    bit rdy_drain, ready_after_start;
    logic [W-1:0] mem0 [512];
    logic [8:0]   a1_q[$];
    logic [W-1:0] d1_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!op_cen0 && !op_wen0) begin
            if (wr_cnt == 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            mem0[op_addr0] = op_d0;
            wr_cnt++;
            if (in_ready0) rdy_drain = 1'b1;
        end
        if (seq_done0) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!op_cen1 && !op_wen1) begin
            a1_q.push_back(op_addr1);
            d1_q.push_back(op_d1);
        end
    end

    function automatic logic [W-1:0] gen_vec(input int mode, input int k, input int p);
        logic [W-1:0] v;
        for (int i = 0; i < 8; i++) begin
            case (mode)
                0:       v[16*i +: 16] = 16'(k + 1);
                1:       v[16*i +: 16] = 16'hFFFF;
                2:       v[16*i +: 16] = (i == 0) ? 16'h7000 : 16'(p + i);
                default: v[16*i +: 16] = (i == 0) ? 16'h9000 : 16'(p + i);
            endcase
        end
        return v;
    endfunction

    function automatic logic [W-1:0] exp_vec(input int mode, input bit relu, input int p);
        logic [W-1:0] v;
        for (int i = 0; i < 8; i++) begin
            case (mode)
                0:       v[16*i +: 16] = 16'h002D;
                1:       v[16*i +: 16] = relu ? 16'h0000 : 16'hFFF7;
                2:       v[16*i +: 16] = (i == 0) ? 16'h7FFF : 16'(9 * (p + i));
                default: v[16*i +: 16] = (i == 0) ? 16'h8000 : 16'(9 * (p + i));
            endcase
        end
        return v;
    endfunction

    task automatic clear_mon();
        wr_cnt = 0; done_cnt = 0; rdy_drain = 1'b0;
        first_wr_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
        a1_q.delete(); d1_q.delete();
        for (int i = 0; i < 512; i++) mem0[i] = 'x;
    endtask

    task automatic send(input logic [W-1:0] v);
        int t = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready0) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready0);
        end
        @(negedge clk);
        last_xfer_cyc = cyc;
        in_valid = 1'b0;
    endtask

    // extras: in_valid high during the start cycle and through DRAIN, plus start pulses in ACCUM and DRAIN.
    task automatic run_seq(input int mode, input bit relu, input int duty, input bit extras);
        int t = 0;
        bit sp = 1'b0;
        clear_mon();
        start = 1'b1; relu_en = relu;
        if (extras) begin in_valid = 1'b1; in_data = {8{16'h1234}}; end
        @(negedge clk);
        ready_after_start = in_ready0;
        start = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            for (int p = 0; p < 16; p++) begin
                while (duty < 100 && $urandom_range(0, 99) >= duty) @(negedge clk);
                if (extras && k == 4 && p == 3) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
                send(gen_vec(mode, k, p));
            end
        end
        if (extras) begin in_valid = 1'b1; in_data = {8{16'h0101}}; end
        while (!seq_done0 && t < 100) begin
            if (extras && !op_cen0 && !sp) begin start = 1'b1; sp = 1'b1; end
            else start = 1'b0;
            @(negedge clk);
            t++;
        end
        start = 1'b0; in_valid = 1'b0;
        if (!seq_done0) begin
            checks++; errors++;
            $display("FAIL seq_done_timeout: seq_done=%0b required 1", seq_done0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy0, in_ready0, op_cen0, op_wen0, seq_done0, sat_flag0} !== 6'b001100) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 001100", {busy0, in_ready0, op_cen0, op_wen0, seq_done0, sat_flag0});
        end
        checks++;
        if (op_addr0 !== 9'd0 || op_d0 !== '0) begin
            errors++;
            $display("FAIL reset_op: addr=%0d d=%h required 0", op_addr0, op_d0);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_sum();
        run_seq(0, 1'b0, 100, 1'b0);
        checks++;
        if (ready_after_start !== 1'b1) begin
            errors++; $display("FAIL ready_after_start: got %b required 1", ready_after_start);
        end
        checks++;
        if (wr_cnt !== 16 || done_cnt !== 1) begin
            errors++; $display("FAIL basic_counts: writes=%0d done=%0d required 16/1", wr_cnt, done_cnt);
        end
        checks++;
        if (first_wr_cyc !== last_xfer_cyc) begin
            errors++; $display("FAIL first_write_latency: write cyc=%0d required %0d", first_wr_cyc, last_xfer_cyc);
        end
        checks++;
        if (done_cyc !== last_wr_cyc + 1) begin
            errors++; $display("FAIL done_timing: done cyc=%0d required %0d", done_cyc, last_wr_cyc + 1);
        end
        for (int p = 0; p < 16; p++) begin
            checks++;
            if (mem0[p] !== exp_vec(0, 1'b0, p)) begin
                errors++; $display("FAIL basic_data[%0d]: got %h required %h", p, mem0[p], exp_vec(0, 1'b0, p));
            end
        end
        checks++;
        if (a1_q.size() !== 16) begin
            errors++; $display("FAIL base500_count: got %0d required 16", a1_q.size());
        end else begin
            for (int j = 0; j < 16; j++) begin
                checks++;
                if ({a1_q[j], d1_q[j]} !== {9'((500 + j) % 512), exp_vec(0, 1'b0, j)}) begin
                    errors++;
                    $display("FAIL base500_write[%0d]: addr=%0d d=%h required addr=%0d d=%h",
                             j, a1_q[j], d1_q[j], (500 + j) % 512, exp_vec(0, 1'b0, j));
                end
            end
        end
    endtask

    task automatic test_relu();
        for (int r = 1; r >= 0; r--) begin
            run_seq(1, r[0], 100, 1'b0);
            for (int p = 0; p < 16; p++) begin
                checks++;
                if (mem0[p] !== exp_vec(1, r[0], p)) begin
                    errors++; $display("FAIL relu%0d_data[%0d]: got %h required %h", r, p, mem0[p], exp_vec(1, r[0], p));
                end
            end
            checks++;
            if (sat_flag0 !== 1'b0) begin
                errors++; $display("FAIL relu%0d_sat_flag: got %b required 0", r, sat_flag0);
            end
        end
    endtask

    task automatic test_saturation();
        for (int m = 2; m <= 3; m++) begin
            run_seq(m, 1'b0, 100, 1'b0);
            for (int p = 0; p < 16; p++) begin
                checks++;
                if (mem0[p] !== exp_vec(m, 1'b0, p)) begin
                    errors++; $display("FAIL sat_mode%0d_data[%0d]: got %h required %h", m, p, mem0[p], exp_vec(m, 1'b0, p));
                end
            end
            checks++;
            if (sat_flag0 !== 1'b1) begin
                errors++; $display("FAIL sat_mode%0d_flag: got %b required 1", m, sat_flag0);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_mon();
        start = 1'b1; relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (sat_flag0 !== 1'b0) begin
            errors++; $display("FAIL sat_clear_on_start: got %b required 0", sat_flag0);
        end
        for (int k = 0; k < 9 && n < 70; k++) begin
            for (int p = 0; p < 16 && n < 70; p++) begin
                send(gen_vec(0, k + 3, p));
                n++;
            end
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || op_cen0 !== 1'b1) begin
            errors++; $display("FAIL reset_mid_abort: busy=%b cen=%b required 0/1", busy0, op_cen0);
        end
        reset = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (wr_cnt !== 0 || done_cnt !== 0) begin
            errors++; $display("FAIL reset_mid_quiet: writes=%0d done=%0d required 0/0", wr_cnt, done_cnt);
        end
        run_seq(0, 1'b0, 100, 1'b0);
        for (int p = 0; p < 16; p++) begin
            checks++;
            if (mem0[p] !== exp_vec(0, 1'b0, p)) begin
                errors++; $display("FAIL after_reset_data[%0d]: got %h required %h", p, mem0[p], exp_vec(0, 1'b0, p));
            end
        end
    endtask

    task automatic test_gaps();
        run_seq(0, 1'b0, 30, 1'b1);
        checks++;
        if (wr_cnt !== 16 || done_cnt !== 1) begin
            errors++; $display("FAIL gaps_counts: writes=%0d done=%0d required 16/1", wr_cnt, done_cnt);
        end
        checks++;
        if (rdy_drain !== 1'b0) begin
            errors++; $display("FAIL gaps_ready_in_drain: got %b required 0", rdy_drain);
        end
        for (int p = 0; p < 16; p++) begin
            checks++;
            if (mem0[p] !== exp_vec(0, 1'b0, p)) begin
                errors++; $display("FAIL gaps_data[%0d]: got %h required %h", p, mem0[p], exp_vec(0, 1'b0, p));
            end
        end
    endtask

    initial begin
        clear_mon();
        @(negedge clk);
        test_reset();
        test_basic_sum();
        test_relu();
        test_saturation();
        test_reset_mid();
        test_gaps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
